// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter stage of the single-cycle RV32I core. Holds the
// architectural PC and selects the next PC from one of three sources:
// sequential (pc + 4), JAL/taken branch (pc + imm) or JALR
// ((rs1_data + imm) & ~1). It also sequences boot, halt and the optional
// misalignment trap, and counts retired instructions.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect target with target[1:0] != 0 stops the core in
//               TRAP. pc holds, and the trap latches bad_target and
//               misaligned.
//   undefined : target[1:0] is forced to 2'b00 before it is loaded into pc.
//               misaligned and bad_target are tied to 0.
//
// Ports
//   clk         in   core clock, rising edge
//   rst         in   synchronous active-high reset
//   stall       in   hold pc, instret and state this cycle (RUN only)
//   jump        in   JAL or taken branch, target = pc + imm
//   jalr        in   JALR, target = (rs1_data + imm) & ~1
//   imm         in   sign-extended immediate
//   rs1_data    in   register-file read port 1
//   halt_req    in   ECALL/EBREAK in the current instruction
//   pc          out  current PC (registered)
//   pc_add4     out  pc + 4, combinational
//   pc_valid    out  pc holds a live instruction (state RUN)
//   halted      out  core is halted (state HALT or TRAP)
//   misaligned  out  sticky misaligned-target trap flag
//   bad_target  out  target that caused the trap
//   instret     out  retired-instruction count
//
// Control semantics: there is no valid/ready handshake. In RUN an
// instruction retires on every clock edge unless stall is high. halt_req
// takes priority over stall because the ECALL/EBREAK itself retires.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 jump,
    input  logic                 jalr,
    input  logic [31:0]          imm,
    input  logic [31:0]          rs1_data,
    input  logic                 halt_req,
    output logic [31:0]          pc,
    output logic [31:0]          pc_add4,
    output logic                 pc_valid,
    output logic                 halted,
    output logic                 misaligned,
    output logic [31:0]          bad_target,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_TRAP = 2'd3;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [31:0] jump_target;
    logic [31:0] jalr_target;
    logic [31:0] target;

    assign pc_add4     = pc_q + 32'd4;
    assign jump_target = pc_q + imm;
    assign jalr_target = (rs1_data + imm) & ~32'h1;

    // JALR outranks jump when both are asserted.
    always_comb begin
        target = pc_add4;
        if (jalr) begin
            target = jalr_target;
        end else if (jump) begin
            target = jump_target;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        misaligned_q, misaligned_d;
    logic [31:0] bad_target_q, bad_target_d;
    // pc is always word aligned, so only a redirect can produce a bad target.
    logic        target_bad;

    assign target_bad = (jump || jalr) && (target[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instret_d    = instret_q;
        misaligned_d = misaligned_q;
        bad_target_d = bad_target_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    instret_d = instret_q + INSTRET_ONE;
                    state_d   = ST_HALT;
                end else if (!stall) begin
                    if (target_bad) begin
                        misaligned_d = 1'b1;
                        bad_target_d = target;
                        state_d      = ST_TRAP;
                    end else begin
                        pc_d      = target;
                        instret_d = instret_q + INSTRET_ONE;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
            bad_target_q <= 32'h0;
        end else begin
            misaligned_q <= misaligned_d;
            bad_target_q <= bad_target_d;
        end
    end

    assign misaligned = misaligned_q;
    assign bad_target = bad_target_q;
`else
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    instret_d = instret_q + INSTRET_ONE;
                    state_d   = ST_HALT;
                end else if (!stall) begin
                    // Without the trap, drop the low target bits so pc stays word aligned.
                    pc_d      = target & ~32'h3;
                    instret_d = instret_q + INSTRET_ONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign misaligned = 1'b0;
    assign bad_target = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign halted   = (state_q == ST_HALT) || (state_q == ST_TRAP);
    assign instret  = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_w;
  logic        stall, jump, jalr, halt_req;
  logic [31:0] imm, rs1_data;

  logic [31:0] pc, pc_add4, bad_target, instret;
  logic        pc_valid, halted, misaligned;

  logic [31:0] w_pc, w_pc_add4, w_bad_target;
  logic        w_pc_valid, w_halted, w_misaligned;
  logic [3:0]  w_instret;

  pc_sequencer #(.RESET_VECTOR(32'h0), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jalr(jalr),
    .imm(imm), .rs1_data(rs1_data), .halt_req(halt_req),
    .pc(pc), .pc_add4(pc_add4), .pc_valid(pc_valid), .halted(halted),
    .misaligned(misaligned), .bad_target(bad_target), .instret(instret)
  );

  // Narrow counter build for the instret wrap check.
  pc_sequencer #(.RESET_VECTOR(32'h0), .INSTRET_W(4)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall), .jump(jump), .jalr(jalr),
    .imm(imm), .rs1_data(rs1_data), .halt_req(halt_req),
    .pc(w_pc), .pc_add4(w_pc_add4), .pc_valid(w_pc_valid), .halted(w_halted),
    .misaligned(w_misaligned), .bad_target(w_bad_target), .instret(w_instret)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; jump = 1'b0; jalr = 1'b0; halt_req = 1'b0;
    imm = 32'h0; rs1_data = 32'h0;
  endtask

  task automatic run_state(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ir);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_instret"}, instret, exp_ir);
    chk({tag, "_pc_valid"}, {31'b0, pc_valid}, 32'd1);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
  endtask

  // Reset for one edge, release, and step through BOOT into RUN.
  task automatic reset_to_run();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    rst   = 1'b1;
    rst_w = 1'b1;

    // Reset and boot
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_bad_target", bad_target, 32'h0);
    chk("rst_pc_add4", pc_add4, 32'h4);
    tick();
    run_state("boot_run", 32'h0, 32'd0);
    tick();
    run_state("seq1", 32'h4, 32'd1);
    tick();
    run_state("seq2", 32'h8, 32'd2);

    // Stall at pc=8 for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jump = 1'b1; imm = 32'h100;
      tick();
      run_state("stall", 32'h8, 32'd2);
    end
    stall = 1'b0; jump = 1'b0; imm = 32'h0;
    tick();
    run_state("stall_release", 32'hC, 32'd3);
    tick();
    run_state("seq3", 32'h10, 32'd4);

    // JAL backwards from 0x10
    jump = 1'b1; imm = 32'hFFFF_FFF0;
    tick();
    run_state("jal_back", 32'h0, 32'd5);

    // jump and jalr together: JALR target wins
    jump = 1'b1; jalr = 1'b1; rs1_data = 32'h100; imm = 32'h4;
    tick();
    run_state("jalr_wins", 32'h104, 32'd6);

    // PC wrap: land on 0xFFFFFFFC, then step sequentially
    jump = 1'b0; jalr = 1'b1; rs1_data = 32'hFFFF_FFF0; imm = 32'hC;
    tick();
    run_state("to_top", 32'hFFFF_FFFC, 32'd7);
    chk("top_pc_add4", pc_add4, 32'h0);
    idle_inputs();
    tick();
    run_state("pc_wrap", 32'h0, 32'd8);

    // JALR bit-0 clear: 0x201 + 2 = 0x203 -> 0x202
    jalr = 1'b1; rs1_data = 32'h201; imm = 32'h2;
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("jalr_trap_pc", pc, 32'h0);
    chk("jalr_trap_instret", instret, 32'd8);
    chk("jalr_trap_misaligned", {31'b0, misaligned}, 32'd1);
    chk("jalr_trap_bad_target", bad_target, 32'h202);
    chk("jalr_trap_halted", {31'b0, halted}, 32'd1);
    chk("jalr_trap_pc_valid", {31'b0, pc_valid}, 32'd0);
    // TRAP ignores further redirects
    idle_inputs();
    jump = 1'b1; imm = 32'h40;
    tick();
    chk("trap_hold_pc", pc, 32'h0);
    chk("trap_hold_bad_target", bad_target, 32'h202);
`else
    run_state("jalr_clear", 32'h200, 32'd9);
    chk("jalr_misaligned", {31'b0, misaligned}, 32'd0);
    chk("jalr_bad_target", bad_target, 32'h0);
`endif

    // Halt at pc=0x40 with instret=5
    reset_to_run();
    run_state("rerun", 32'h0, 32'd0);
    tick(); tick(); tick(); tick();
    run_state("pre_halt_seq", 32'h10, 32'd4);
    jump = 1'b1; imm = 32'h30;
    tick();
    run_state("pre_halt_jump", 32'h40, 32'd5);
    halt_req = 1'b1; jump = 1'b1; jalr = 1'b1; imm = 32'h8; rs1_data = 32'h80;
    tick();
    chk("halt_pc", pc, 32'h40);
    chk("halt_instret", instret, 32'd6);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_pc_valid", {31'b0, pc_valid}, 32'd0);
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      jump = 1'b1; jalr = (i % 2) == 0; imm = $urandom_range(1, 255) << 2;
      rs1_data = 32'h1000;
      tick();
      chk("halt_hold_pc", pc, 32'h40);
      chk("halt_hold_instret", instret, 32'd6);
      chk("halt_hold_halted", {31'b0, halted}, 32'd1);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", {31'b0, halted}, 32'd0);
    chk("halt_rst_pc_valid", {31'b0, pc_valid}, 32'd0);
    chk("halt_rst_instret", instret, 32'd0);
    tick();
    run_state("halt_rst_run", 32'h0, 32'd0);

    // stall and halt_req together: halt wins, ECALL retires
    stall = 1'b1; halt_req = 1'b1;
    tick();
    chk("stall_halt_halted", {31'b0, halted}, 32'd1);
    chk("stall_halt_pc", pc, 32'h0);
    chk("stall_halt_instret", instret, 32'd1);

    // Misaligned JAL target (imm=6 from pc=0)
    reset_to_run();
    jump = 1'b1; imm = 32'h6;
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("jal_mis_pc", pc, 32'h0);
    chk("jal_mis_misaligned", {31'b0, misaligned}, 32'd1);
    chk("jal_mis_bad_target", bad_target, 32'h6);
    chk("jal_mis_instret", instret, 32'd0);
`else
    run_state("jal_mis_forced", 32'h4, 32'd1);
`endif

    // instret wrap on the 4-bit build: 15 -> 0
    idle_inputs();
    rst_w = 1'b0;
    tick();
    chk("w_boot_instret", {28'b0, w_instret}, 32'd0);
    chk("w_boot_pc_valid", {31'b0, w_pc_valid}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("w_instret_max", {28'b0, w_instret}, 32'd15);
    chk("w_pc_at_max", w_pc, 32'h3C);
    tick();
    chk("w_instret_wrap", {28'b0, w_instret}, 32'd0);
    chk("w_pc_after_wrap", w_pc, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle RV32I core. Holds the architectural PC and selects the next PC: sequential, JAL/branch, or JALR.
- Supplies pc and pc_add4 to the fetch path and to the downstream LUI/AUIPC/JAL/JALR result adder.
- Adds boot, halt and optional misalignment-trap sequencing, plus a retired-instruction counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and counter this cycle.
- jump  input  1  JAL or taken conditional branch; target = pc + imm.
- jalr  input  1  JALR; target = (rs1_data + imm) & ~32'h1.
- imm  input  32  sign-extended immediate from the immediate generator.
- rs1_data  input  32  register-file read port 1.
- halt_req  input  1  ECALL/EBREAK decoded in the current instruction.
- pc  output  32  current PC (registered).
- pc_add4  output  32  pc + 4, combinational, modulo 2^32.
- pc_valid  output  1  current pc holds a live instruction.
- halted  output  1  core is halted.
- misaligned  output  1  sticky misaligned-target trap flag.
- bad_target  output  32  target that caused the trap.
- instret  output  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (rst=1 at clock edge, from any state, including mid-stall or HALT):
  - pc=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0, misaligned=0, bad_target=0, instret=0.
- States: BOOT, RUN, HALT, TRAP. State is registered; pc_valid and halted are decoded from the state register.
- BOOT:
  - pc_valid=0; pc holds.
  - Next cycle goes to RUN unconditionally, ignoring all inputs. This gives instruction memory one fetch cycle.
- RUN (pc_valid=1). Priority per cycle: halt_req > stall > redirect/sequential.
  - halt_req=1: pc holds, instret+1 (ECALL retires), next state HALT. Overrides stall, jump and jalr.
  - stall=1 (no halt_req): pc, instret and state hold.
  - Otherwise pc <= next_pc and instret+1.
  - next_pc priority: jalr > jump > pc_add4. jump and jalr together: the JALR target wins.
- Arithmetic:
  - All adds are 32-bit, wrap modulo 2^32, no overflow flag. Example: pc=32'hFFFF_FFFC sequential gives 32'h0000_0000.
  - JALR always clears bit 0 of its target.
  - instret wraps to 0 after all-ones.
- HALT: pc_valid=0, halted=1. pc and instret are frozen. All inputs are ignored. Only rst exits.
- TRAP: entered only when the optional feature is enabled.
  - pc_valid=0, halted=1, misaligned=1, bad_target held. Only rst exits.
- Latency:
  - A redirect presented in cycle N appears on pc in cycle N+1.
  - pc_add4 follows pc in the same cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In RUN, unstalled, no halt_req, the selected target (after JALR bit-0 clear) is checked.
  - If target[1:0] != 2'b00: pc holds, bad_target <= target, misaligned <= 1, instret does not increment, next state TRAP.
  - Sequential pc_add4 targets never trap.
- Not defined:
  - target[1:0] is forced to 2'b00 before loading pc.
  - misaligned and bad_target are tied to 0.
  - The TRAP state is unreachable and may be omitted.

Test Plan:
- Reset and boot: assert rst 2 cycles, release. Required: pc=0 and pc_valid=0 in the first cycle after release; pc_valid=1 the next cycle; then pc steps 0,4,8 with instret 0,1,2.
- JAL redirect: at pc=32'h10, jump=1, imm=32'hFFFF_FFF0. Required: next pc=32'h0, instret+1. Also drive jump=1 and jalr=1 together with rs1_data=32'h100, imm=4: next pc=32'h104.
- JALR bit-0 clear: rs1_data=32'h201, imm=32'h2, jalr=1. Required: target 32'h202 after bit-0 clear. Without the macro pc=32'h200; with the macro misaligned=1, bad_target=32'h202, state TRAP, pc unchanged.
- Stall: at pc=32'h8, stall=1 for 3 cycles. Required: pc=32'h8 and instret unchanged throughout; pc=32'hC one cycle after stall drops. Also drive stall=1 with halt_req=1: HALT is entered.
- Halt: at pc=32'h40 with instret=5, halt_req=1. Required: next cycle halted=1, pc_valid=0, pc=32'h40, instret=6; jump/jalr ignored for 4 cycles; rst returns pc to RESET_VECTOR and state to BOOT.
- Wrap: pc=32'hFFFF_FFFC sequential gives pc=32'h0. With instret preloaded to 32'hFFFF_FFFF via repeated steps (reduced INSTRET_W=4 build: 15 → 0), instret wraps to 0.
